// File: rtl/crop_pkg.sv
// Shared types and helpers for the run-time configurable crop window stage.
package crop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } crop_state_t;

  // Width needed to index n items; never narrower than one bit.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CFG_CALC_W = 32;

endpackage

// File: rtl/crop_out_slice.sv
// Single-entry AXI-Stream register slice carrying data and last.
module crop_out_slice #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);

  // A full register can still take a new beat when downstream drains it this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/crop_window_stream.sv
// Crops a decimated OUT_ROWS x OUT_COLS window from a raster frame; origin and
// stride are latched at ap_start and range-checked.
module crop_window_stream
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int IN_ROWS         = 100,
  parameter int IN_COLS         = 160,
  parameter int OUT_ROWS        = 48,
  parameter int OUT_COLS        = 48,
  parameter int STRIDE_W        = 3
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  output logic                       ap_ready,
  input  logic [cw(IN_ROWS)-1:0]     cfg_y1,
  input  logic [cw(IN_COLS)-1:0]     cfg_x1,
  input  logic [STRIDE_W-1:0]        cfg_stride,
  output logic                       cfg_err,
  input  logic [PIXEL_BIT_WIDTH-1:0] crop_input_TDATA,
  input  logic                       crop_input_TVALID,
  output logic                       crop_input_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0] crop_output_TDATA,
  output logic                       crop_output_TVALID,
  input  logic                       crop_output_TREADY,
  output logic                       crop_output_TLAST
);

  localparam int ROW_W     = cw(IN_ROWS);
  localparam int COL_W     = cw(IN_COLS);
  localparam int OROW_W    = cw(OUT_ROWS + 1);
  localparam int OCOL_W    = cw(OUT_COLS + 1);
  localparam int OUT_TOTAL = OUT_ROWS * OUT_COLS;
  localparam int CNT_W     = cw(OUT_TOTAL + 1);

  typedef logic [PIXEL_BIT_WIDTH-1:0] pixel_t;

  crop_state_t         state, state_next;
  logic [ROW_W-1:0]    y1_q, row;
  logic [COL_W-1:0]    x1_q, col;
  logic [STRIDE_W-1:0] stride_q, row_phase, col_phase;
  logic [OROW_W-1:0]   rows_taken;
  logic [OCOL_W-1:0]   cols_taken;
  logic [CNT_W-1:0]    out_count;

  logic [CFG_CALC_W-1:0] y_end, x_end;
  logic   cfg_ok, start_accept;
  logic   slice_in_ready, in_fire, last_row, last_col, frame_end;
  logic   row_in, col_in, row_sel, col_sel, pix_sel, last_in;
  pixel_t pix_in;

  // Window extents in a wide domain so large strides cannot wrap.
  always_comb begin
    y_end  = CFG_CALC_W'(cfg_y1) + CFG_CALC_W'(OUT_ROWS - 1) * CFG_CALC_W'(cfg_stride);
    x_end  = CFG_CALC_W'(cfg_x1) + CFG_CALC_W'(OUT_COLS - 1) * CFG_CALC_W'(cfg_stride);
    cfg_ok = (cfg_stride != '0) && (y_end < CFG_CALC_W'(IN_ROWS))
             && (x_end < CFG_CALC_W'(IN_COLS));
  end

  assign start_accept      = (state == ST_IDLE) && ap_start;
  assign crop_input_TREADY = (state == ST_RUN) && slice_in_ready;
  assign in_fire           = crop_input_TVALID && crop_input_TREADY;
  assign last_row          = (row == ROW_W'(IN_ROWS - 1));
  assign last_col          = (col == COL_W'(IN_COLS - 1));
  assign frame_end         = in_fire && last_row && last_col;

  // Phase counters advance only inside the window, so phase 0 marks stride hits.
  assign row_in  = (row >= y1_q);
  assign col_in  = (col >= x1_q);
  assign row_sel = row_in && (row_phase == '0) && (rows_taken < OROW_W'(OUT_ROWS));
  assign col_sel = col_in && (col_phase == '0) && (cols_taken < OCOL_W'(OUT_COLS));
  assign pix_sel = in_fire && row_sel && col_sel;
  assign last_in = (out_count == CNT_W'(OUT_TOTAL - 1));
  assign pix_in  = crop_input_TDATA;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      y1_q       <= '0;
      x1_q       <= '0;
      stride_q   <= '0;
      cfg_err    <= 1'b0;
      row        <= '0;
      col        <= '0;
      row_phase  <= '0;
      col_phase  <= '0;
      rows_taken <= '0;
      cols_taken <= '0;
      out_count  <= '0;
    end else if (start_accept) begin
      y1_q       <= cfg_y1;
      x1_q       <= cfg_x1;
      stride_q   <= cfg_stride;
      cfg_err    <= !cfg_ok;
      row        <= '0;
      col        <= '0;
      row_phase  <= '0;
      col_phase  <= '0;
      rows_taken <= '0;
      cols_taken <= '0;
      out_count  <= '0;
    end else if (in_fire) begin
      if (pix_sel) out_count <= out_count + 1'b1;
      if (last_col) begin
        col        <= '0;
        col_phase  <= '0;
        cols_taken <= '0;
        row        <= last_row ? '0 : row + 1'b1;
        if (row_in) row_phase <= (row_phase == stride_q - 1'b1) ? '0 : row_phase + 1'b1;
        if (row_sel) rows_taken <= rows_taken + 1'b1;
      end else begin
        col <= col + 1'b1;
        if (col_in) col_phase <= (col_phase == stride_q - 1'b1) ? '0 : col_phase + 1'b1;
        if (col_sel) cols_taken <= cols_taken + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ap_idle    = 1'b0;
    ap_done    = 1'b0;
    ap_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_next = cfg_ok ? ST_RUN : ST_DONE;
      end
      ST_RUN:   if (frame_end) state_next = ST_DRAIN;
      ST_DRAIN: if (!crop_output_TVALID) state_next = ST_DONE;
      ST_DONE: begin
        ap_done    = 1'b1;
        ap_ready   = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  crop_out_slice #(
    .W(PIXEL_BIT_WIDTH)
  ) u_out_slice (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .in_valid (pix_sel),
    .in_data  (pix_in),
    .in_last  (last_in),
    .in_ready (slice_in_ready),
    .out_valid(crop_output_TVALID),
    .out_data (crop_output_TDATA),
    .out_last (crop_output_TLAST),
    .out_ready(crop_output_TREADY)
  );

endmodule

// File: tb/tb_crop_window_stream.sv
// Bench for crop_window_stream on an 8x10 frame cropped to 3x3, pixel = r*10+c.
module tb_crop_window_stream;

  localparam int PW    = 16;
  localparam int IR    = 8;
  localparam int IC    = 10;
  localparam int OUT_R = 3;
  localparam int OUT_C = 3;
  localparam int SW    = 3;
  localparam int LIMIT = 3000;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, ap_ready, cfg_err;
  logic [2:0]    cfg_y1 = '0;
  logic [3:0]    cfg_x1 = '0;
  logic [SW-1:0] cfg_stride = '0;
  logic [PW-1:0] crop_input_TDATA = '0;
  logic          crop_input_TVALID = 1'b0;
  logic          crop_input_TREADY;
  logic [PW-1:0] crop_output_TDATA;
  logic          crop_output_TVALID;
  logic          crop_output_TREADY = 1'b0;
  logic          crop_output_TLAST;

  crop_window_stream #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IR), .IN_COLS(IC),
    .OUT_ROWS(OUT_R), .OUT_COLS(OUT_C), .STRIDE_W(SW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .cfg_y1(cfg_y1), .cfg_x1(cfg_x1), .cfg_stride(cfg_stride), .cfg_err(cfg_err),
    .crop_input_TDATA(crop_input_TDATA), .crop_input_TVALID(crop_input_TVALID),
    .crop_input_TREADY(crop_input_TREADY),
    .crop_output_TDATA(crop_output_TDATA), .crop_output_TVALID(crop_output_TVALID),
    .crop_output_TREADY(crop_output_TREADY), .crop_output_TLAST(crop_output_TLAST)
  );

  initial forever #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Monitor state, cleared at the start of each frame.
  int in_count, done_count, done_run, done_max_run, ready_diff, tready_high;
  int stall_viol, hold_tready, hold_data_bad, hold_samples, src_cycles;
  bit hold_active = 0, aborted = 0, timed_out = 0, prev_stall = 0;
  logic [PW-1:0] prev_data;
  logic          prev_last;
  logic [PW-1:0] got_data[$];
  bit            got_last[$];
  logic [PW-1:0] exp_q[$];
  bit            exp_ok;

  // Observes the values that the next rising edge will act on.
  initial forever begin
    @(negedge ap_clk);
    if (ap_rst) begin
      prev_stall = 0;
    end else begin
      if (crop_input_TVALID && crop_input_TREADY) in_count++;
      if (crop_input_TREADY) tready_high++;
      if (crop_output_TVALID && crop_output_TREADY) begin
        got_data.push_back(crop_output_TDATA);
        got_last.push_back(crop_output_TLAST);
      end
      if (prev_stall && (!crop_output_TVALID || crop_output_TDATA !== prev_data ||
                         crop_output_TLAST !== prev_last))
        stall_viol++;
      prev_stall = crop_output_TVALID && !crop_output_TREADY;
      prev_data  = crop_output_TDATA;
      prev_last  = crop_output_TLAST;
      if (ap_done) begin
        done_count++;
        done_run++;
        if (done_run > done_max_run) done_max_run = done_run;
      end else begin
        done_run = 0;
      end
      if (ap_done !== ap_ready) ready_diff++;
      if (hold_active) begin
        hold_samples++;
        if (crop_input_TREADY) hold_tready++;
        if (crop_output_TDATA !== '0) hold_data_bad++;
      end
    end
  end

  // Reference window computed directly from the selection rule.
  function automatic void build_expected(input int y1, input int x1, input int s);
    exp_q.delete();
    exp_ok = (s != 0) && (y1 + (OUT_R - 1) * s < IR) && (x1 + (OUT_C - 1) * s < IC);
    if (!exp_ok) return;
    for (int r = 0; r < IR; r++)
      for (int c = 0; c < IC; c++)
        if (r >= y1 && (r - y1) % s == 0 && (r - y1) / s < OUT_R &&
            c >= x1 && (c - x1) % s == 0 && (c - x1) / s < OUT_C)
          exp_q.push_back(PW'(r * 10 + c));
  endfunction

  function automatic void clear_monitor();
    got_data.delete();
    got_last.delete();
    in_count = 0; done_count = 0; done_run = 0; done_max_run = 0; ready_diff = 0;
    tready_high = 0; stall_viol = 0; hold_tready = 0; hold_data_bad = 0;
    hold_samples = 0; aborted = 0; timed_out = 0;
  endfunction

  task automatic run_frame(input int y1, input int x1, input int s, input bit src_rand,
                           input bit snk_rand, input int hold_cycles, input int abort_after,
                           input int restart_at);
    int s_idx, s_cyc, k_cyc, hc;
    bit seen, restarted;
    clear_monitor();
    s_idx = 0; s_cyc = 0; k_cyc = 0; hc = 0; seen = 0; restarted = 0;
    @(posedge ap_clk); #1;
    cfg_y1 = 3'(y1); cfg_x1 = 4'(x1); cfg_stride = SW'(s); ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    fork
      begin
        while (s_idx < IR * IC && done_count == 0 && s_cyc < LIMIT) begin
          crop_input_TVALID = src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
          crop_input_TDATA  = PW'((s_idx / IC) * 10 + s_idx % IC);
          if (!restarted && s_idx == restart_at) begin
            ap_start = 1'b1; cfg_y1 = '0; cfg_x1 = '0; cfg_stride = SW'(1);
            restarted = 1;
          end
          @(negedge ap_clk);
          if (crop_input_TVALID && crop_input_TREADY) s_idx++;
          @(posedge ap_clk); #1;
          ap_start = 1'b0;
          s_cyc++;
          if (abort_after > 0 && s_idx == abort_after) begin
            aborted = 1;
            break;
          end
        end
        crop_input_TVALID = 1'b0;
        src_cycles = s_cyc;
        if (s_cyc >= LIMIT) timed_out = 1;
      end
      begin
        while (done_count == 0 && !aborted && k_cyc < LIMIT) begin
          if (hold_cycles > 0 && !seen && crop_output_TVALID) begin
            seen = 1;
            hold_active = 1;
          end
          if (hold_active) begin
            crop_output_TREADY = 1'b0;
            hc++;
            if (hc > hold_cycles) hold_active = 0;
          end
          if (!hold_active)
            crop_output_TREADY = (hold_cycles > 0 && !seen) ? 1'b0 :
                                 (snk_rand ? 1'($urandom_range(0, 1)) : 1'b1);
          @(posedge ap_clk); #1;
          k_cyc++;
        end
        if (k_cyc >= LIMIT) timed_out = 1;
      end
    join
    hold_active = 0;
    if (!aborted) begin
      crop_output_TREADY = 1'b1;
      repeat (4) @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [PW-1:0] obs[8];
    logic [PW-1:0] want[8];
    string         nm[8];
    @(negedge ap_clk);
    nm[0] = "reset_idle";   obs[0] = PW'(ap_idle);            want[0] = 1;
    nm[1] = "reset_done";   obs[1] = PW'(ap_done);            want[1] = 0;
    nm[2] = "reset_ready";  obs[2] = PW'(ap_ready);           want[2] = 0;
    nm[3] = "reset_err";    obs[3] = PW'(cfg_err);            want[3] = 0;
    nm[4] = "reset_itrdy";  obs[4] = PW'(crop_input_TREADY);  want[4] = 0;
    nm[5] = "reset_ovalid"; obs[5] = PW'(crop_output_TVALID); want[5] = 0;
    nm[6] = "reset_olast";  obs[6] = PW'(crop_output_TLAST);  want[6] = 0;
    nm[7] = "reset_odata";  obs[7] = crop_output_TDATA;       want[7] = 0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (obs[i] !== want[i]) begin
        n_fails++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], obs[i], want[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [PW-1:0] want[9] = '{23, 25, 27, 43, 45, 47, 63, 65, 67};
    run_frame(2, 3, 2, 0, 0, 0, 0, -1);
    n_checks++;
    if (timed_out || got_data.size() != 9) begin
      n_fails++;
      $display("[TB] FAIL basic_count: got %0d beats (timeout %0d) expected 9", got_data.size(), timed_out);
    end
    for (int i = 0; i < got_data.size() && i < 9; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_last[i] !== (i == 8)) begin
        n_fails++;
        $display("[TB] FAIL basic_beat%0d: got %0d/last %0d expected %0d/last %0d",
                 i, got_data[i], got_last[i], want[i], i == 8);
      end
    end
    n_checks++;
    if (done_count != 1 || done_max_run != 1 || ready_diff != 0) begin
      n_fails++;
      $display("[TB] FAIL basic_done: got %0d pulses width %0d ready_diff %0d expected 1/1/0",
               done_count, done_max_run, ready_diff);
    end
    n_checks++;
    if (in_count != 80 || src_cycles != 80) begin
      n_fails++;
      $display("[TB] FAIL basic_inputs: got %0d beats in %0d cycles expected 80 in 80", in_count, src_cycles);
    end
  endtask

  task automatic test_invalid();
    int tbl[3][3] = '{'{5, 0, 2}, '{0, 0, 0}, '{0, 7, 2}};
    for (int t = 0; t < 3; t++) begin
      clear_monitor();
      @(posedge ap_clk); #1;
      cfg_y1 = 3'(tbl[t][0]); cfg_x1 = 4'(tbl[t][1]); cfg_stride = SW'(tbl[t][2]);
      ap_start = 1'b1; crop_input_TVALID = 1'b1; crop_output_TREADY = 1'b1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      @(negedge ap_clk);
      n_checks++;
      if (ap_done !== 1'b1 || ap_ready !== 1'b1 || cfg_err !== 1'b1 || ap_idle !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL invalid%0d_k1: got done %b ready %b err %b idle %b expected 1 1 1 0",
                 t, ap_done, ap_ready, cfg_err, ap_idle);
      end
      @(negedge ap_clk);
      n_checks++;
      if (ap_idle !== 1'b1 || ap_done !== 1'b0 || cfg_err !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL invalid%0d_k2: got idle %b done %b err %b expected 1 0 1",
                 t, ap_idle, ap_done, cfg_err);
      end
      repeat (3) @(negedge ap_clk);
      crop_input_TVALID = 1'b0;
      n_checks++;
      if (tready_high != 0 || in_count != 0 || got_data.size() != 0 || done_count != 1) begin
        n_fails++;
        $display("[TB] FAIL invalid%0d_quiet: got tready %0d in %0d out %0d done %0d expected 0 0 0 1",
                 t, tready_high, in_count, got_data.size(), done_count);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] want[9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
    run_frame(0, 0, 1, 0, 0, 20, 0, -1);
    n_checks++;
    if (hold_samples < 20 || hold_tready != 0 || hold_data_bad != 0 || stall_viol != 0) begin
      n_fails++;
      $display("[TB] FAIL bp_hold: got samples %0d tready %0d data_bad %0d stall %0d expected >=20 0 0 0",
               hold_samples, hold_tready, hold_data_bad, stall_viol);
    end
    n_checks++;
    if (timed_out || got_data.size() != 9 || cfg_err !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL bp_count: got %0d beats err %b expected 9 err 0", got_data.size(), cfg_err);
    end
    for (int i = 0; i < got_data.size() && i < 9; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_last[i] !== (i == 8)) begin
        n_fails++;
        $display("[TB] FAIL bp_beat%0d: got %0d/last %0d expected %0d", i, got_data[i], got_last[i], want[i]);
      end
    end
  endtask

  task automatic test_random_handshake();
    logic [PW-1:0] want[9] = '{10, 13, 16, 40, 43, 46, 70, 73, 76};
    run_frame(1, 0, 3, 1, 1, 0, 0, -1);
    n_checks++;
    if (timed_out || got_data.size() != 9 || in_count != 80 || stall_viol != 0) begin
      n_fails++;
      $display("[TB] FAIL rand_summary: got %0d beats %0d inputs %0d stall expected 9 80 0",
               got_data.size(), in_count, stall_viol);
    end
    for (int i = 0; i < got_data.size() && i < 9; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_last[i] !== (i == 8)) begin
        n_fails++;
        $display("[TB] FAIL rand_beat%0d: got %0d/last %0d expected %0d", i, got_data[i], got_last[i], want[i]);
      end
    end
  endtask

  task automatic test_random_cfg();
    int y1, x1, s;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin y1 = 3; x1 = 5; s = 2; end
      else if (t == 1) begin y1 = 4; x1 = 6; s = 2; end
      else begin
        y1 = int'($urandom_range(0, IR - 1));
        x1 = int'($urandom_range(0, IC - 1));
        s  = int'($urandom_range(0, 4));
      end
      build_expected(y1, x1, s);
      run_frame(y1, x1, s, 1, 1, 0, 0, -1);
      n_checks++;
      if (timed_out || cfg_err !== !exp_ok || done_count != 1 || in_count != (exp_ok ? 80 : 0)) begin
        n_fails++;
        $display("[TB] FAIL cfg%0d_status (y1=%0d x1=%0d s=%0d): got err %b done %0d in %0d expected err %b done 1 in %0d",
                 t, y1, x1, s, cfg_err, done_count, in_count, !exp_ok, exp_ok ? 80 : 0);
      end
      n_checks++;
      if (got_data.size() != exp_q.size()) begin
        n_fails++;
        $display("[TB] FAIL cfg%0d_count: got %0d beats expected %0d", t, got_data.size(), exp_q.size());
      end
      for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
          n_fails++;
          $display("[TB] FAIL cfg%0d_beat%0d: got %0d/last %0d expected %0d", t, i, got_data[i], got_last[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [PW-1:0] want[9] = '{23, 25, 27, 43, 45, 47, 63, 65, 67};
    run_frame(0, 0, 1, 0, 0, 0, 30, -1);
    n_checks++;
    if (in_count != 30) begin
      n_fails++;
      $display("[TB] FAIL midrst_inputs: got %0d expected 30", in_count);
    end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    n_checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0 || cfg_err !== 1'b0 ||
        crop_input_TREADY !== 1'b0 || crop_output_TVALID !== 1'b0 ||
        crop_output_TLAST !== 1'b0 || crop_output_TDATA !== '0) begin
      n_fails++;
      $display("[TB] FAIL midrst_values: got idle %b done %b rdy %b err %b itr %b ov %b ol %b od %0h expected 1 0 0 0 0 0 0 0",
               ap_idle, ap_done, ap_ready, cfg_err, crop_input_TREADY, crop_output_TVALID,
               crop_output_TLAST, crop_output_TDATA);
    end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    run_frame(2, 3, 2, 0, 0, 0, 0, -1);
    n_checks++;
    if (timed_out || got_data.size() != 9 || in_count != 80 || done_count != 1) begin
      n_fails++;
      $display("[TB] FAIL midrst_rerun: got %0d beats %0d inputs %0d done expected 9 80 1",
               got_data.size(), in_count, done_count);
    end
    for (int i = 0; i < got_data.size() && i < 9; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_last[i] !== (i == 8)) begin
        n_fails++;
        $display("[TB] FAIL midrst_beat%0d: got %0d/last %0d expected %0d", i, got_data[i], got_last[i], want[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [PW-1:0] want[9] = '{10, 13, 16, 40, 43, 46, 70, 73, 76};
    run_frame(1, 0, 3, 0, 1, 0, 0, 20);
    n_checks++;
    if (timed_out || done_count != 1 || done_max_run != 1 || in_count != 80 || got_data.size() != 9) begin
      n_fails++;
      $display("[TB] FAIL restart_summary: got done %0d width %0d in %0d out %0d expected 1 1 80 9",
               done_count, done_max_run, in_count, got_data.size());
    end
    for (int i = 0; i < got_data.size() && i < 9; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_last[i] !== (i == 8)) begin
        n_fails++;
        $display("[TB] FAIL restart_beat%0d: got %0d/last %0d expected %0d", i, got_data[i], got_last[i], want[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge ap_clk);
    test_reset();
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    test_basic();
    test_invalid();
    test_backpressure();
    test_random_handshake();
    test_random_cfg();
    test_mid_reset();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
